// File: rtl/prisoner_warden.sv
`default_nettype none
// ============================================================================
//  Module   : prisoner_warden
//  Purpose  : Loads, clears and plays the 100-prisoners loop strategy against
//             an array of prisoner_box instances. Optional: EARLY_ABORT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module prisoner_warden #(
    parameter int          NUM_BOXES = 8,
    parameter int          MAX_OPENS = NUM_BOXES / 2,
    parameter logic [31:0] KEY       = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic [7:0]                 load_data,
    output logic                       load_ready,
    input  logic                       start,
    input  logic                       clear,
    output logic [3*NUM_BOXES-1:0]     box_state,
    output logic [7:0]                 box_wdata,
    output logic [31:0]                box_key,
    input  logic [8*NUM_BOXES-1:0]     box_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [8:0]                 fail_count,
    output logic [15:0]                open_count,
    output logic                       bad_content
);

    localparam int                IDX_W      = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BOXES - 1);
    localparam logic [8:0]        NUM_BOX_W  = 9'(NUM_BOXES);
    localparam logic [8:0]        MAX_OPEN_W = 9'(MAX_OPENS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_OPEN  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         load_idx_q, load_idx_d;
    logic [IDX_W-1:0]         prisoner_q, prisoner_d;
    logic [IDX_W-1:0]         cur_box_q, cur_box_d;
    logic [8:0]               opens_q, opens_d;
    logic [15:0]              open_count_q, open_count_d;
    logic [8:0]               fail_count_q, fail_count_d;
    logic                     pass_q, pass_d;
    logic                     bad_q, bad_d;
    logic [3*NUM_BOXES-1:0]   box_state_q, box_state_d;
    logic [7:0]               box_wdata_q, box_wdata_d;
    logic [31:0]              box_key_q, box_key_d;

    logic [7:0]               v;
    logic [8:0]               opens_inc;
    logic                     finish;
    logic                     failed;
    logic                     abort;

    assign load_ready  = (state_q == S_IDLE) && !clear && !start;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign fail_count  = fail_count_q;
    assign open_count  = open_count_q;
    assign bad_content = bad_q;
    assign box_state   = box_state_q;
    assign box_wdata   = box_wdata_q;
    assign box_key     = box_key_q;

    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        prisoner_d   = prisoner_q;
        cur_box_d    = cur_box_q;
        opens_d      = opens_q;
        open_count_d = open_count_q;
        fail_count_d = fail_count_q;
        pass_d       = pass_q;
        bad_d        = bad_q;
        box_state_d  = '0;
        box_wdata_d  = '0;
        box_key_d    = '0;
        v            = box_rdata[int'(cur_box_q)*8 +: 8];
        opens_inc    = opens_q + 9'd1;
        finish       = 1'b0;
        failed       = 1'b0;
        abort        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d     = S_CLEAR;
                    box_state_d = {NUM_BOXES{3'b100}};
                    load_idx_d  = '0;
                end else if (start) begin
                    state_d      = S_OPEN;
                    prisoner_d   = '0;
                    cur_box_d    = '0;
                    opens_d      = '0;
                    open_count_d = '0;
                    fail_count_d = '0;
                    pass_d       = 1'b0;
                    bad_d        = 1'b0;
                end else if (load_valid) begin
                    // Outputs are registered, so the LOAD cycle sees the old index.
                    state_d = S_LOAD;
                    box_state_d[int'(load_idx_q)*3 +: 3] = 3'b001;
                    box_wdata_d = load_data;
                    box_key_d   = KEY;
                    load_idx_d  = (load_idx_q == LAST_IDX) ? '0 : load_idx_q + IDX_W'(1);
                end
            end
            S_LOAD, S_CLEAR, S_DONE: state_d = S_IDLE;
            S_OPEN: begin
                open_count_d = (open_count_q == 16'hFFFF) ? open_count_q : open_count_q + 16'd1;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                opens_d = opens_inc;
                if (v == 8'(prisoner_q)) begin
                    finish = 1'b1;
                end else if ({1'b0, v} >= NUM_BOX_W) begin
                    bad_d  = 1'b1;
                    finish = 1'b1;
                    failed = 1'b1;
                end else if (opens_inc == MAX_OPEN_W) begin
                    finish = 1'b1;
                    failed = 1'b1;
                end else begin
                    cur_box_d = v[IDX_W-1:0];
                    state_d   = S_OPEN;
                end

`ifdef EARLY_ABORT_EN
                abort = failed;
`else
                abort = 1'b0;
`endif
                if (finish) begin
                    fail_count_d = fail_count_q + 9'(failed);
                    if ((prisoner_q == LAST_IDX) || abort) begin
                        state_d = S_DONE;
                        pass_d  = (fail_count_d == 9'd0);
                    end else begin
                        prisoner_d = prisoner_q + IDX_W'(1);
                        cur_box_d  = prisoner_q + IDX_W'(1);
                        opens_d    = '0;
                        state_d    = S_OPEN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The open command is issued one cycle ahead so it lands in the OPEN cycle.
        if (state_d == S_OPEN)
            box_state_d[int'(cur_box_d)*3 +: 3] = 3'b010;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_idx_q   <= '0;
            prisoner_q   <= '0;
            cur_box_q    <= '0;
            opens_q      <= '0;
            open_count_q <= '0;
            fail_count_q <= '0;
            pass_q       <= 1'b0;
            bad_q        <= 1'b0;
            box_state_q  <= '0;
            box_wdata_q  <= '0;
            box_key_q    <= '0;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            prisoner_q   <= prisoner_d;
            cur_box_q    <= cur_box_d;
            opens_q      <= opens_d;
            open_count_q <= open_count_d;
            fail_count_q <= fail_count_d;
            pass_q       <= pass_d;
            bad_q        <= bad_d;
            box_state_q  <= box_state_d;
            box_wdata_q  <= box_wdata_d;
            box_key_q    <= box_key_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prisoner_warden.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prisoner_warden
//  Purpose  : Directed bench for prisoner_warden with a behavioural box array.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prisoner_warden;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic          start;
    logic          clear;
    logic [3*N-1:0] box_state;
    logic [7:0]    box_wdata;
    logic [31:0]   box_key;
    logic [8*N-1:0] box_rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [8:0]    fail_count;
    logic [15:0]   open_count;
    logic          bad_content;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem  [N];
    logic [7:0] outr [N];

    always #5 clk = ~clk;

    prisoner_warden #(.NUM_BOXES(N)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .clear(clear),
        .box_state(box_state), .box_wdata(box_wdata), .box_key(box_key),
        .box_rdata(box_rdata),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .open_count(open_count), .bad_content(bad_content)
    );

    // Behavioural box: keyed load, registered output, reset to zero.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            case (box_state[3*i +: 3])
                3'b001: if (box_key == 32'hDEADBEEF) mem[i] <= box_wdata;
                3'b010: outr[i] <= mem[i];
                3'b100: begin mem[i] <= 8'd0; outr[i] <= 8'd0; end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_box
        assign box_rdata[8*g +: 8] = outr[g];
    end

    task automatic test_reset;
        rst = 1'b1; load_valid = 1'b0; load_data = 8'd0; start = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", load_ready); end
        checks++; if (box_state !== '0)    begin errors++; $display("FAIL reset_box_state got %h want 0", box_state); end
        checks++; if (box_key !== 32'd0)   begin errors++; $display("FAIL reset_key got %h want 0", box_key); end
        checks++; if ({pass, bad_content, fail_count, open_count} !== '0)
            begin errors++; $display("FAIL reset_results got %b/%b/%0d/%0d want 0", pass, bad_content, fail_count, open_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_box(input logic [7:0] d, input int idx);
        load_valid = 1'b1; load_data = d;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d] got %b want 1", idx, load_ready); end
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (box_state !== (24'd1 << (3*idx)))
            begin errors++; $display("FAIL load_state[%0d] got %h want %h", idx, box_state, 24'd1 << (3*idx)); end
        checks++; if (box_key !== 32'hDEADBEEF) begin errors++; $display("FAIL load_key[%0d] got %h want deadbeef", idx, box_key); end
        checks++; if (box_wdata !== d) begin errors++; $display("FAIL load_wdata[%0d] got %h want %h", idx, box_wdata, d); end
        @(negedge clk);
    endtask

    // kind: 0 identity, 1 single 8-cycle, 2 two 4-cycles, 3 box0 bad
    task automatic load_pattern(input int kind);
        logic [7:0] d;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: d = 8'(i);
                1: d = 8'((i + 1) % 8);
                2: d = 8'((i & 4) | ((i + 1) & 3));
                default: d = (i == 0) ? 8'hFF : 8'(i);
            endcase
            load_box(d, i);
        end
    endtask

    task automatic do_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (box_state !== {N{3'b100}}) begin errors++; $display("FAIL clear_state got %h want %h", box_state, {N{3'b100}}); end
        checks++; if (box_key !== 32'd0) begin errors++; $display("FAIL clear_key got %h want 0", box_key); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got %b want 1", busy); end
        @(negedge clk);
    endtask

    task automatic run_game(input string nm, input logic e_pass, input logic [8:0] e_fail,
                            input logic [15:0] e_open, input logic e_bad, input int e_cyc,
                            input bit poke);
        int cyc;
        int keyseen;
        keyseen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b want 1", nm, busy); end
        checks++; if (box_state !== 24'h000002) begin errors++; $display("FAIL %s first_open got %h want 000002", nm, box_state); end
        while (done !== 1'b1 && cyc < 500) begin
            if (box_key !== 32'd0) keyseen++;
            if (poke && cyc == 3) begin
                start = 1'b1; load_valid = 1'b1; load_data = 8'h55;
                #1;
                checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL %s ready_busy got %b want 0", nm, load_ready); end
            end else begin
                start = 1'b0; load_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; load_valid = 1'b0;
        checks++; if (cyc >= 500) begin errors++; $display("FAIL %s timeout got %0d cycles want done", nm, cyc); end
        checks++; if (cyc != e_cyc) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", nm, cyc, e_cyc); end
        checks++; if (pass !== e_pass) begin errors++; $display("FAIL %s pass got %b want %b", nm, pass, e_pass); end
        checks++; if (fail_count !== e_fail) begin errors++; $display("FAIL %s fail_count got %0d want %0d", nm, fail_count, e_fail); end
        checks++; if (open_count !== e_open) begin errors++; $display("FAIL %s open_count got %0d want %0d", nm, open_count, e_open); end
        checks++; if (bad_content !== e_bad) begin errors++; $display("FAIL %s bad_content got %b want %b", nm, bad_content, e_bad); end
        checks++; if (keyseen != 0) begin errors++; $display("FAIL %s key_in_game got %0d want 0", nm, keyseen); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done got %b%b want 00", nm, done, busy); end
        checks++; if (pass !== e_pass) begin errors++; $display("FAIL %s pass_hold got %b want %b", nm, pass, e_pass); end
    endtask

    task automatic test_identity;
        load_pattern(0);
        run_game("identity", 1'b1, 9'd0, 16'd8, 1'b0, 17, 1'b0);
    endtask

    task automatic test_shift;
        do_clear();
        load_pattern(1);
`ifdef EARLY_ABORT_EN
        run_game("shift", 1'b0, 9'd1, 16'd4, 1'b0, 9, 1'b0);
`else
        run_game("shift", 1'b0, 9'd8, 16'd32, 1'b0, 65, 1'b0);
`endif
    endtask

    task automatic test_two_cycles_busy_ignore;
        do_clear();
        load_pattern(2);
        run_game("two_cycles", 1'b1, 9'd0, 16'd32, 1'b0, 65, 1'b1);
        run_game("two_cycles_rerun", 1'b1, 9'd0, 16'd32, 1'b0, 65, 1'b0);
    endtask

    task automatic test_bad_content;
        do_clear();
        load_pattern(3);
`ifdef EARLY_ABORT_EN
        run_game("bad_content", 1'b0, 9'd1, 16'd1, 1'b1, 3, 1'b0);
`else
        run_game("bad_content", 1'b0, 9'd1, 16'd8, 1'b1, 17, 1'b0);
`endif
    endtask

    task automatic test_clear_game;
        do_clear();
`ifdef EARLY_ABORT_EN
        run_game("cleared", 1'b0, 9'd1, 16'd5, 1'b0, 11, 1'b0);
`else
        run_game("cleared", 1'b0, 9'd7, 16'd29, 1'b0, 59, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_game;
        do_clear();
        load_pattern(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (box_state !== '0) begin errors++; $display("FAIL midrst_state got %h want 0", box_state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (open_count !== 16'd0) begin errors++; $display("FAIL midrst_opens got %0d want 0", open_count); end
        rst = 1'b0;
        @(negedge clk);
`ifdef EARLY_ABORT_EN
        run_game("after_reset", 1'b0, 9'd1, 16'd4, 1'b0, 9, 1'b0);
`else
        run_game("after_reset", 1'b0, 9'd8, 16'd32, 1'b0, 65, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_identity();
        test_shift();
        test_two_cycles_busy_ignore();
        test_bad_content();
        test_clear_game();
        test_reset_mid_game();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prisoner_warden.md
Name: prisoner_warden

Overview:
Sequencer for an array of NUM_BOXES prisoner_box instances. It loads box contents from a host stream, clears the array, and plays the 100-prisoners loop strategy against the boxes. Each prisoner p starts at box p and follows the box contents for at most MAX_OPENS opens. The block sits between host/testbench control and the box array, and owns every box's state_reg, input_data and guard_key.

Parameters:
NUM_BOXES, 8, number of boxes and prisoners; legal range 2..256
MAX_OPENS, NUM_BOXES/2, opens allowed per prisoner; legal range 1..NUM_BOXES
KEY, 32'hDEADBEEF, value driven on guard_key during load commands

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
load_valid  in  1  host offers the next box content
load_data  in  8  content for box load_idx
load_ready  out  1  high only in IDLE with no clear/start this cycle
start  in  1  one-cycle pulse; runs the game, sampled in IDLE only
clear  in  1  one-cycle pulse; resets all boxes, sampled in IDLE only
box_state  out  3*NUM_BOXES  per-box one-hot command, box i at [3i+2:3i]; 001 load, 010 output, 100 reset, 000 hold
box_wdata  out  8  shared input_data to all boxes
box_key  out  32  shared guard_key to all boxes
box_rdata  in  8*NUM_BOXES  box output_data, box i at [8i+7:8i]
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a game ends
pass  out  1  all prisoners found their number; valid from done until the next start
fail_count  out  9  prisoners that failed
open_count  out  16  total opens in the last game
bad_content  out  1  an opened box held a value >= NUM_BOXES

Behaviour:
- Reset values. All outputs are 0, except load_ready, which is 1 in IDLE. Internal reset values: FSM=IDLE, load_idx=0.
- Box contents are not touched by rst. Reset mid-operation aborts immediately and the next cycle shows reset values.
- All box_* outputs are registered. box_key = KEY only in cycles where some box_state = 001; otherwise 0.
- States: IDLE, LOAD, CLEAR, OPEN, CHECK, DONE.
- IDLE priority is clear > start > load handshake.
- LOAD: a handshake in IDLE enters LOAD for 1 cycle.
  - Drives box_state[load_idx] = 001, box_wdata = load_data, box_key = KEY, then returns to IDLE.
  - load_idx increments and wraps NUM_BOXES-1 -> 0.
- CLEAR: drives 100 to all boxes for 1 cycle, sets load_idx = 0, returns to IDLE.
- start: clears pass, fail_count, open_count and bad_content. Sets prisoner = 0, cur_box = 0, opens = 0, then goes to OPEN.
- OPEN: 1 cycle; box_state[cur_box] = 010. open_count increments, saturating at 16'hFFFF.
- CHECK: samples v = box_rdata[cur_box], which the box registered at the end of OPEN. opens increments.
  - v == prisoner (8-bit compare, prisoner zero-extended): prisoner succeeds.
  - v >= NUM_BOXES: bad_content = 1 and the prisoner fails immediately.
  - opens == MAX_OPENS: prisoner fails.
  - Otherwise cur_box = v and the FSM goes to OPEN.
- Prisoner finish: on success or failure, fail_count increments if failed. If prisoner == NUM_BOXES-1, go to DONE. Otherwise prisoner++, cur_box = prisoner+1, opens = 0, go to OPEN.
- Timing: each open costs 2 cycles. No gap between prisoners.
- DONE: 1 cycle. done = 1, pass = (fail_count == 0) computed including the last prisoner. Then IDLE.
- box_state is 000 in every cycle not named above.
- start, clear and load_valid are ignored while busy.

Optional Feature:
EARLY_ABORT_EN.
- Defined: the first prisoner failure goes straight to DONE with pass = 0. fail_count = 1, and open_count holds the opens so far.
- Undefined: all NUM_BOXES prisoners always play.

Test Plan:
- Identity load 0..7 (N=8), start at cycle t -> OPEN at t+1; done at t+17, pass=1, fail_count=0, open_count=8, bad_content=0.
- Load box i = (i+1)%8 (single 8-cycle), start -> pass=0, fail_count=8, open_count=32. With EARLY_ABORT_EN: fail_count=1, open_count=4.
- Load box i = (i&4)|((i+1)&3) (two 4-cycles), start -> pass=1, fail_count=0, open_count=32.
- Load box0=8'hFF, boxes 1..7 identity, start -> bad_content=1, fail_count=1, open_count=8.
- clear pulse -> one cycle with all box_state=100 and box_key=0. start -> prisoner 0 passes, 1..7 fail; fail_count=7, open_count=29. box_key=DEADBEEF only during LOAD cycles.
- rst asserted during CHECK -> next cycle busy=0, box_state=0, done=0. Restarting gives identical results to an uninterrupted run. start and load_valid asserted while busy -> no effect.
